// File: rtl/vx_cache_mshr_pkg.sv
// Shared types for the cache-bank MSHR chain: entry and walker states plus per-entry link metadata.
// Link pointers are sized for the largest supported bank; narrower banks use the low bits.
package vx_cache_mshr_pkg;

  localparam int MSHR_ID_MAX_W = 8;

  typedef enum logic {
    ENTRY_FREE = 1'b0,
    ENTRY_WAIT = 1'b1
  } entry_state_e;

  typedef enum logic {
    WALK_IDLE = 1'b0,
    WALK_BUSY = 1'b1
  } walk_state_e;

  typedef struct packed {
    entry_state_e             state;
    logic                     tail;
    logic                     next_valid;
    logic [MSHR_ID_MAX_W-1:0] next;
  } mshr_meta_t;

endpackage

// File: rtl/vx_cache_mshr_chain_lzc.sv
// VX_lzc: index of the lowest set request bit, combinational (0 latency).
// No backpressure; valid is low when no request bit is set.
module VX_lzc #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] index,
  output logic         valid
);

  always_comb begin
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) index = W'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/vx_cache_mshr_chain.sv
// Cache-bank MSHR: secondary misses link behind the primary; a fill replays the chain one entry per cycle.
// Fill-to-first-replay latency 1 cycle; replay holds under dequeue_ready=0, fill_ready low while walking.
module vx_cache_mshr_chain
  import vx_cache_mshr_pkg::*;
#(
  parameter int MSHR_SIZE       = 16,
  parameter int LINE_ADDR_WIDTH = 26,
  parameter int DATA_WIDTH      = 64,
  parameter int ID_WIDTH        = $clog2(MSHR_SIZE)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       allocate_valid,
  input  logic [LINE_ADDR_WIDTH-1:0] allocate_addr,
  input  logic [DATA_WIDTH-1:0]      allocate_data,
  output logic                       allocate_ready,
  output logic [ID_WIDTH-1:0]        allocate_id,
  output logic                       allocate_primary,
  input  logic                       fill_valid,
  input  logic [ID_WIDTH-1:0]        fill_id,
  output logic                       fill_ready,
  output logic [LINE_ADDR_WIDTH-1:0] fill_addr,
  output logic                       dequeue_valid,
  output logic [ID_WIDTH-1:0]        dequeue_id,
  output logic [LINE_ADDR_WIDTH-1:0] dequeue_addr,
  output logic [DATA_WIDTH-1:0]      dequeue_data,
  input  logic                       dequeue_ready,
  output logic [ID_WIDTH:0]          occupancy,
  output logic                       full
);

  localparam int OCC_W = ID_WIDTH + 1;

  mshr_meta_t                 meta_q [MSHR_SIZE];
  logic [LINE_ADDR_WIDTH-1:0] addr_q [MSHR_SIZE];
  logic [DATA_WIDTH-1:0]      data_q [MSHR_SIZE];
  walk_state_e                walk_q;
  logic [ID_WIDTH-1:0]        ptr_q;
  logic [OCC_W-1:0]           occ_q;

  logic [MSHR_SIZE-1:0] free_mask;
  logic [MSHR_SIZE-1:0] match;
  logic [MSHR_SIZE-1:0] link_sel;
  logic [MSHR_SIZE-1:0] linked;
  logic                 free_any;
  logic                 alloc_fire;
  logic                 deq_fire;
  logic                 fill_fire;

  VX_lzc #(
    .N (MSHR_SIZE),
    .W (ID_WIDTH)
  ) free_sel (
    .req   (free_mask),
    .index (allocate_id),
    .valid (free_any)
  );

  assign full           = (occ_q == OCC_W'(MSHR_SIZE));
  assign allocate_ready = !full;
  assign fill_ready     = (walk_q == WALK_IDLE);
  assign dequeue_valid  = (walk_q == WALK_BUSY);
  assign dequeue_id     = ptr_q;
  assign dequeue_addr   = addr_q[ptr_q];
  assign dequeue_data   = data_q[ptr_q];
  assign fill_addr      = addr_q[fill_id];
  assign occupancy      = occ_q;

  assign alloc_fire = allocate_valid && allocate_ready;
  assign deq_fire   = dequeue_valid && dequeue_ready;
  assign fill_fire  = fill_valid && fill_ready;

  // A tail leaving this cycle cannot take a link: the new miss starts its own chain instead.
  always_comb begin
    free_mask = '0;
    match     = '0;
    link_sel  = '0;
    for (int i = 0; i < MSHR_SIZE; i++) begin
      free_mask[i] = (meta_q[i].state == ENTRY_FREE);
      match[i]     = (meta_q[i].state == ENTRY_WAIT) && meta_q[i].tail && (addr_q[i] == allocate_addr);
      link_sel[i]  = match[i] && !(deq_fire && (ptr_q == ID_WIDTH'(i)));
    end
  end

  assign allocate_primary = !(|link_sel);

  always_comb begin
    linked = '0;
    for (int i = 0; i < MSHR_SIZE; i++) begin
      if ((meta_q[i].state == ENTRY_WAIT) && meta_q[i].next_valid) linked[meta_q[i].next[ID_WIDTH-1:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MSHR_SIZE; i++) begin
        meta_q[i] <= '{state: ENTRY_FREE, tail: 1'b0, next_valid: 1'b0, next: '0};
      end
      walk_q <= WALK_IDLE;
      ptr_q  <= '0;
      occ_q  <= '0;
    end else begin
      for (int i = 0; i < MSHR_SIZE; i++) begin
        if (deq_fire && (ptr_q == ID_WIDTH'(i))) meta_q[i].state <= ENTRY_FREE;
        if (alloc_fire && link_sel[i]) begin
          meta_q[i].tail       <= 1'b0;
          meta_q[i].next_valid <= 1'b1;
          meta_q[i].next       <= MSHR_ID_MAX_W'(allocate_id);
        end
        if (alloc_fire && (allocate_id == ID_WIDTH'(i))) begin
          meta_q[i].state      <= ENTRY_WAIT;
          meta_q[i].tail       <= 1'b1;
          meta_q[i].next_valid <= 1'b0;
        end
      end
      if (fill_fire) begin
        walk_q <= WALK_BUSY;
        ptr_q  <= fill_id;
      end else if (deq_fire) begin
        if (meta_q[ptr_q].next_valid) ptr_q <= meta_q[ptr_q].next[ID_WIDTH-1:0];
        else                          walk_q <= WALK_IDLE;
      end
      occ_q <= occ_q + OCC_W'(alloc_fire) - OCC_W'(deq_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      addr_q[allocate_id] <= allocate_addr;
      data_q[allocate_id] <= allocate_data;
    end
  end

  if (MSHR_ID_MAX_W > ID_WIDTH) begin : g_next_hi
    logic [MSHR_SIZE-1:0] unused_next_hi;
    for (genvar i = 0; i < MSHR_SIZE; i++) begin : g_entry
      assign unused_next_hi[i] = |meta_q[i].next[MSHR_ID_MAX_W-1:ID_WIDTH];
    end
  end

  a_single_tail_match: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(match));
  a_fill_when_ready:   assert property (@(posedge clk) disable iff (!reset_n) fill_valid |-> fill_ready);
  a_fill_head:         assert property (@(posedge clk) disable iff (!reset_n)
                         fill_fire |-> (meta_q[fill_id].state == ENTRY_WAIT) && !linked[fill_id]);
  a_free_consistent:   assert property (@(posedge clk) disable iff (!reset_n) free_any == !full);

endmodule

// File: tb/tb_vx_cache_mshr_chain.sv
// Randomized + directed bench: chain-level reference model feeds a replay scoreboard checked by a monitor.
module tb_vx_cache_mshr_chain;

  localparam int N  = 16;
  localparam int AW = 26;
  localparam int DW = 64;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          allocate_valid;
  logic [AW-1:0] allocate_addr;
  logic [DW-1:0] allocate_data;
  logic          allocate_ready;
  logic [IW-1:0] allocate_id;
  logic          allocate_primary;
  logic          fill_valid;
  logic [IW-1:0] fill_id;
  logic          fill_ready;
  logic [AW-1:0] fill_addr;
  logic          dequeue_valid;
  logic [IW-1:0] dequeue_id;
  logic [AW-1:0] dequeue_addr;
  logic [DW-1:0] dequeue_data;
  logic          dequeue_ready;
  logic [IW:0]   occupancy;
  logic          full;

  vx_cache_mshr_chain dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .allocate_valid   (allocate_valid),
    .allocate_addr    (allocate_addr),
    .allocate_data    (allocate_data),
    .allocate_ready   (allocate_ready),
    .allocate_id      (allocate_id),
    .allocate_primary (allocate_primary),
    .fill_valid       (fill_valid),
    .fill_id          (fill_id),
    .fill_ready       (fill_ready),
    .fill_addr        (fill_addr),
    .dequeue_valid    (dequeue_valid),
    .dequeue_id       (dequeue_id),
    .dequeue_addr     (dequeue_addr),
    .dequeue_data     (dequeue_data),
    .dequeue_ready    (dequeue_ready),
    .occupancy        (occupancy),
    .full             (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   nchk = 0;
  int   nfail = 0;

  // Reference model: entries are busy or not; chains are plain id queues.
  bit            m_busy [N];
  logic [AW-1:0] m_addr [N];
  logic [DW-1:0] m_data [N];
  int            m_cnt;
  int            rem [N][$];  // unfilled chains keyed by their primary
  int            pend[$];     // primaries awaiting a fill
  bit            m_walk;
  int            wrem[$];     // not-yet-replayed part of the chain being walked
  logic [AW-1:0] waddr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
    return 0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 1'b0;
      rem[i].delete();
    end
    m_cnt = 0;
    m_walk = 1'b0;
    wrem.delete();
    pend.delete();
    exp_q.delete();
  endfunction

  task automatic tick(input bit av, input logic [AW-1:0] aa, input bit fv, input int fid, input bit dr,
                      output logic [IW-1:0] id_o, output logic prim_o);
    logic [DW-1:0] ad;
    int  exp_id, lk_p, id;
    bit  a_fire, d_fire, f_fire, lk_walk;
    ad = {$urandom, $urandom};
    allocate_valid = av;
    allocate_addr  = aa;
    allocate_data  = ad;
    fill_valid     = fv;
    fill_id        = IW'(fid);
    dequeue_ready  = dr;
    #1;
    exp_id  = lowest_free();
    a_fire  = av && (m_cnt < N);
    d_fire  = m_walk && dr;
    f_fire  = fv && !m_walk;
    lk_walk = 1'b0;
    lk_p    = -1;
    if (m_walk && (waddr == aa) && !(d_fire && wrem.size() == 1)) lk_walk = 1'b1;
    else foreach (pend[k]) if (m_addr[pend[k]] == aa) lk_p = pend[k];

    chk("occupancy", occupancy, m_cnt);
    chk("full", full, m_cnt == N);
    chk("allocate_ready", allocate_ready, m_cnt < N);
    chk("fill_ready", fill_ready, !m_walk);
    chk("dequeue_valid", dequeue_valid, m_walk);
    if (m_cnt < N) chk("allocate_id", allocate_id, exp_id);
    if (a_fire) chk("allocate_primary", allocate_primary, !(lk_walk || lk_p >= 0));
    if (fv) chk("fill_addr", fill_addr, m_addr[fid]);
    id_o   = allocate_id;
    prim_o = allocate_primary;

    @(posedge clk);
    if (d_fire) begin
      id = wrem.pop_front();
      m_busy[id] = 1'b0;
      m_cnt--;
      if (wrem.size() == 0) m_walk = 1'b0;
    end
    if (a_fire) begin
      id = exp_id;
      m_busy[id] = 1'b1;
      m_addr[id] = aa;
      m_data[id] = ad;
      m_cnt++;
      if (lk_walk) begin
        wrem.push_back(id);
        exp_q.push_back('{id, aa, ad});
      end else if (lk_p >= 0) begin
        rem[lk_p].push_back(id);
      end else begin
        rem[id].delete();
        rem[id].push_back(id);
        pend.push_back(id);
      end
    end
    if (f_fire) begin
      m_walk = 1'b1;
      waddr  = m_addr[fid];
      wrem   = rem[fid];
      foreach (wrem[k]) exp_q.push_back('{wrem[k], m_addr[wrem[k]], m_data[wrem[k]]});
      rem[fid].delete();
      for (int k = pend.size() - 1; k >= 0; k--) if (pend[k] == fid) pend.delete(k);
    end
    @(negedge clk);
  endtask

  task automatic step(input bit av, input logic [AW-1:0] aa, input bit fv, input int fid, input bit dr);
    logic [IW-1:0] id_d;
    logic          prim_d;
    tick(av, aa, fv, fid, dr, id_d, prim_d);
  endtask

  task automatic drain();
    int guard = 0;
    while ((pend.size() > 0 || m_walk) && guard < 2000) begin
      if (!m_walk) step(1'b0, '0, 1'b1, pend[0], 1'b1);
      else         step(1'b0, '0, 1'b0, 0, 1'b1);
      guard++;
    end
    chk("drain_occupancy", occupancy, 0);
    chk("drain_scoreboard_empty", exp_q.size(), 0);
  endtask

  // Monitor: every presented replay must match the scoreboard head; pop on fire.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset_n === 1'b1 && dequeue_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("deq_unexpected_valid", dequeue_valid, 0);
        end else begin
          chk("deq_id", dequeue_id, exp_q[0].id);
          chk("deq_addr", dequeue_addr, exp_q[0].addr);
          chk("deq_data", dequeue_data, exp_q[0].data);
          if (dequeue_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [IW-1:0] id0, id1, id2;
    logic          p0, p1, p2;
    logic [DW-1:0] held;
    int            guard;

    allocate_valid = 0; allocate_addr = '0; allocate_data = '0;
    fill_valid = 0; fill_id = '0; dequeue_ready = 0;
    model_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dequeue_valid", dequeue_valid, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_full", full, 0);
    chk("rst_fill_ready", fill_ready, 1);
    chk("rst_allocate_ready", allocate_ready, 1);
    chk("rst_allocate_id", allocate_id, 0);
    reset_n = 1'b1;

    // Primary allocation and single-entry replay
    tick(1, 26'h100, 0, 0, 1, id0, p0);
    chk("t2_id", id0, 0);
    chk("t2_primary", p0, 1);
    step(0, '0, 1, 0, 1);
    chk("t2_deq_valid", dequeue_valid, 1);
    chk("t2_deq_addr", dequeue_addr, 26'h100);
    step(0, '0, 0, 0, 1);
    chk("t2_occupancy", occupancy, 0);

    // Chaining behind one primary
    tick(1, 26'h200, 0, 0, 1, id0, p0);
    tick(1, 26'h200, 0, 0, 1, id1, p1);
    tick(1, 26'h200, 0, 0, 1, id2, p2);
    chk("t3_ids", {id0, id1, id2}, {4'd0, 4'd1, 4'd2});
    chk("t3_primary", {p0, p1, p2}, 3'b100);
    step(0, '0, 1, 0, 1);
    repeat (3) step(0, '0, 0, 0, 1);
    chk("t3_valid_drop", dequeue_valid, 0);

    // Full boundary
    for (int i = 0; i < N; i++) step(1, 26'h1000 + AW'(i), 0, 0, 1);
    chk("t4_full", full, 1);
    chk("t4_allocate_ready", allocate_ready, 0);
    step(1, 26'h2000, 0, 0, 1);
    step(0, '0, 1, 5, 1);
    step(0, '0, 0, 0, 1);
    chk("t4_full_drop", full, 0);
    tick(1, 26'h2000, 0, 0, 1, id0, p0);
    chk("t4_realloc_id", id0, 5);
    drain();

    // Allocate in the same cycle as the tail leaves: new primary, walk ends
    for (int i = 0; i < 4; i++) step(1, 26'h300, 0, 0, 1);
    step(0, '0, 1, 0, 1);
    repeat (3) step(0, '0, 0, 0, 1);
    tick(1, 26'h300, 0, 0, 1, id0, p0);
    chk("t5_same_cycle_primary", p0, 1);
    chk("t5_walker_idle", dequeue_valid, 0);
    drain();
    // One cycle earlier: linked and streamed
    for (int i = 0; i < 4; i++) step(1, 26'h300, 0, 0, 1);
    step(0, '0, 1, 0, 1);
    repeat (2) step(0, '0, 0, 0, 1);
    tick(1, 26'h300, 0, 0, 1, id0, p0);
    chk("t5_early_linked", p0, 0);
    chk("t5_early_id", id0, 0);
    guard = 0;
    while (m_walk && guard < 50) begin
      step(0, '0, 0, 0, 1);
      guard++;
    end
    chk("t5_walk_end_occupancy", occupancy, 0);

    // Backpressure mid-chain
    for (int i = 0; i < 4; i++) step(1, 26'h400, 0, 0, 1);
    step(0, '0, 1, 0, 1);
    repeat (2) step(0, '0, 0, 0, 1);
    held = dequeue_data;
    for (int i = 0; i < 4; i++) begin
      step(0, '0, 0, 0, 0);
      chk("t6_hold_id", dequeue_id, 2);
      chk("t6_hold_data", dequeue_data, held);
      chk("t6_hold_occupancy", occupancy, 2);
    end
    drain();

    // Reset during a walk
    step(1, 26'h500, 0, 0, 1);
    step(1, 26'h500, 0, 0, 1);
    step(0, '0, 1, 0, 1);
    step(0, '0, 0, 0, 0);
    allocate_valid = 0; fill_valid = 0; dequeue_ready = 0;
    reset_n = 1'b0;
    #1;
    chk("t1_rst_dequeue_valid", dequeue_valid, 0);
    chk("t1_rst_occupancy", occupancy, 0);
    chk("t1_rst_allocate_id", allocate_id, 0);
    chk("t1_rst_fill_ready", fill_ready, 1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized traffic over a few hot lines
    for (int c = 0; c < 600; c++) begin
      bit            av, fv, dr;
      logic [AW-1:0] aa;
      int            fid;
      av  = ($urandom_range(0, 99) < 55);
      aa  = 26'h40 + AW'($urandom_range(0, 3));
      fv  = 1'b0;
      fid = 0;
      if (!m_walk && pend.size() > 0 && $urandom_range(0, 3) == 0) begin
        fv  = 1'b1;
        fid = pend[$urandom_range(0, pend.size() - 1)];
      end
      dr = ($urandom_range(0, 3) != 0);
      step(av, aa, fv, fid, dr);
    end
    drain();

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
